pipe_hazard_ctrl: RTL

Parametrised pipeline control block that generates per-stage stall, kill and redirect (flush) signals for an N-stage in-order core.
- Stall requests are per stage; a request holds that stage and every younger stage.
- Multiple flush sources (branch/jump, trap, interrupt, debug) are priority-resolved.
- A redirect that fetch cannot take immediately is held in a pending register until accepted.
- Saturating stall/flush performance counters and a long-stall watchdog flag are included.
- Sits between decode/execute/CLINT/JTAG request sources and the PC/IF/ID/EX pipeline registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// flush source indices and the stage-index width helper.
package pipe_hazard_ctrl_pkg;

    // Pipeline stage indices, youngest (PC) to oldest (EX).
    localparam int STAGE_PC = 0;
    localparam int STAGE_IF = 1;
    localparam int STAGE_ID = 2;
    localparam int STAGE_EX = 3;

    // Flush source indices; a higher index has higher priority.
    localparam int FLUSH_JUMP = 0;
    localparam int FLUSH_INT  = 1;

    // Width of a stage index. A single-stage pipeline still gets one bit,
    // so that the flush_stage port never collapses to zero width.
    function automatic int calc_sw(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear. Clear wins over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear first, then increment unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/kill generation, prioritised
// redirect selection with a pending register for redirects fetch cannot take
// yet, saturating stall/flush counters and a long-stall watchdog.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int NUM_FLUSH   = 2,
    parameter int AW          = 32,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_STAGES-1:0]                  stall_req_i,
    input  logic [NUM_FLUSH-1:0]                   flush_req_i,
    input  logic [NUM_FLUSH*AW-1:0]                flush_addr_i,
    input  logic [NUM_FLUSH*calc_sw(NUM_STAGES)-1:0] flush_stage_i,
    input  logic                                   flush_ready_i,
    input  logic                                   clr_cnt_i,
    output logic [NUM_STAGES-1:0]                  stall_o,
    output logic [NUM_STAGES-1:0]                  kill_o,
    output logic                                   flush_o,
    output logic [AW-1:0]                          flush_addr_o,
    output logic [CNT_W-1:0]                       stall_cyc_o,
    output logic [CNT_W-1:0]                       flush_cnt_o,
    output logic                                   stall_long_o
);

    localparam int SW = calc_sw(NUM_STAGES);
    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    logic                  r_pending_vld;
    logic [AW-1:0]         r_pending_addr;
    logic [CW-1:0]         r_consec;
    logic                  r_stall_long;

    logic                  w_any_req;
    logic [AW-1:0]         w_sel_addr;
    logic [SW-1:0]         w_sel_stage;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_kill;
    logic                  w_flush;
    logic [AW-1:0]         w_flush_addr;
    logic [CW-1:0]         w_consec_next;
    logic                  w_accept;

    assign w_any_req = |flush_req_i;

    // Priority select: later (higher-index) sources overwrite earlier ones.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_stage = '0;
        for (int f = 0; f < NUM_FLUSH; f++) begin
            if (flush_req_i[f]) begin
                w_sel_addr  = flush_addr_i[f*AW +: AW];
                w_sel_stage = flush_stage_i[f*SW +: SW];
            end
        end
    end

    // A stall request at stage k holds k and every younger stage. The PC
    // stage is also held while a redirect is waiting for fetch, so no new
    // fetch address races the pending one. Kill bubbles every stage younger
    // than the one that raised the winning redirect, only in the request
    // cycle; the pending state never kills again.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_pc
                assign w_stall[gi] = (|stall_req_i) | r_pending_vld;
            end else begin : g_older
                assign w_stall[gi] = |stall_req_i[NUM_STAGES-1:gi];
            end
            assign w_kill[gi] = w_any_req && (w_sel_stage > SW'(gi));
        end
    endgenerate

    // A fresh request always has the newest target, so it outranks pending.
    assign w_flush      = w_any_req | r_pending_vld;
    assign w_flush_addr = w_any_req ? w_sel_addr : r_pending_addr;
    assign w_accept     = w_flush & flush_ready_i;

    // Pending redirect: capture whatever is being presented while fetch is
    // busy (latest request wins), drop it once fetch is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_vld  <= 1'b0;
            r_pending_addr <= '0;
        end else if (flush_ready_i) begin
            r_pending_vld  <= 1'b0;
        end else if (w_flush) begin
            r_pending_vld  <= 1'b1;
            r_pending_addr <= w_flush_addr;
        end
    end

    // Consecutive PC-stall count: clear wins, any unstalled cycle restarts
    // the run, and the count parks at the limit.
    always_comb begin
        w_consec_next = r_consec;
        if (clr_cnt_i) begin
            w_consec_next = '0;
        end else if (!w_stall[0]) begin
            w_consec_next = '0;
        end else if (r_consec != LIMIT) begin
            w_consec_next = r_consec + 1'b1;
        end
    end

    // Watchdog state and its registered flag, updated from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_consec     <= '0;
            r_stall_long <= 1'b0;
        end else begin
            r_consec     <= w_consec_next;
            r_stall_long <= (w_consec_next == LIMIT);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall[0]),
        .i_clr (clr_cnt_i),
        .o_cnt (stall_cyc_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_accept),
        .i_clr (clr_cnt_i),
        .o_cnt (flush_cnt_o)
    );

    assign stall_o      = w_stall;
    assign kill_o       = w_kill;
    assign flush_o      = w_flush;
    assign flush_addr_o = w_flush_addr;
    assign stall_long_o = r_stall_long;

endmodule : pipe_hazard_ctrl
